// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared receiver FSM states, parity/prescale constants and the majority helper
package uart_rx_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CHECK} state_e;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD = 1'b1;
   localparam logic [5:0] PRESCALE_8 = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;
   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction
endpackage

// File: rtl/uart_rx_data_sampling.sv
// uart_rx_data_sampling: takes three line samples around mid-bit and registers their 2-of-3 majority
module uart_rx_data_sampling
   import uart_rx_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_in,
   input  logic [5:0] prescale,
   input  logic [5:0] edge_cnt,
   output logic       sampled_bit
);
   logic [5:0] half;
   logic [2:0] s_q, s_d;
   logic bit_q, bit_d;
   assign half = prescale >> 1;
   assign sampled_bit = bit_q;
   // capture samples at P/2-1, P/2, P/2+1 and vote at P/2+2
   always_comb begin
      s_d = {edge_cnt == half + 6'd1 ? rx_in : s_q[2],
             edge_cnt == half ? rx_in : s_q[1],
             edge_cnt == half - 6'd1 ? rx_in : s_q[0]};
      bit_d = edge_cnt == half + 6'd2 ? maj3(s_q) : bit_q;
   end
   // sample and vote registers; idle line level after reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q <= 3'b111;
         bit_q <= 1'b1;
      end else begin
         s_q <= s_d;
         bit_q <= bit_d;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity, stop-bit check and valid/error pulses
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int Data_width = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic [5:0]            Prescale,
   output logic [Data_width-1:0] P_DATA,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stp_err
);
   localparam int BW = $clog2(Data_width + 1);
   state_e state_q, state_d;
   logic [5:0] edge_q, edge_d, p_q, p_d;
   logic [BW-1:0] bit_q, bit_d;
   logic par_en_q, par_en_d, par_typ_q, par_typ_d;
   logic par_pend_q, par_pend_d, stp_pend_q, stp_pend_d;
   logic [Data_width-1:0] shift_q, shift_d, p_data_q, p_data_d;
   logic sampled_bit, last;
   uart_rx_data_sampling u_sampling (
      .clk         (CLK),
      .rst         (RST),
      .rx_in       (RX_IN),
      .prescale    (p_q),
      .edge_cnt    (edge_q),
      .sampled_bit (sampled_bit)
   );
   assign last = edge_q == p_q - 6'd1;
   assign P_DATA = p_data_q;
   assign data_valid = state_q == CHECK && !par_pend_q && !stp_pend_q;
   assign par_err = state_q == CHECK && par_pend_q;
   assign stp_err = state_q == CHECK && stp_pend_q;
   // next state, bit timing, deserialiser and error bookkeeping; every decision lands on edge P-1
   always_comb begin
      state_d = state_q;
      edge_d = last ? 6'd0 : edge_q + 6'd1;
      bit_d = bit_q;
      p_d = p_q;
      par_en_d = par_en_q;
      par_typ_d = par_typ_q;
      par_pend_d = par_pend_q;
      stp_pend_d = stp_pend_q;
      shift_d = shift_q;
      p_data_d = p_data_q;
      case (state_q)
         IDLE: begin
            edge_d = 6'd0;
            if (!RX_IN) begin
               state_d = START;
               edge_d = 6'd1;
               p_d = Prescale;
               par_en_d = PAR_EN;
               par_typ_d = PAR_TYP;
               par_pend_d = 1'b0;
               stp_pend_d = 1'b0;
               bit_d = '0;
            end
         end
         START: if (last) state_d = sampled_bit ? IDLE : DATA;
         DATA: if (last) begin
            shift_d = {sampled_bit, shift_q[Data_width-1:1]};
            bit_d = bit_q + 1'b1;
            if (bit_q == BW'(Data_width - 1)) begin
               bit_d = '0;
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: if (last) begin
            par_pend_d = sampled_bit != (par_typ_q == PAR_ODD ? ~^shift_q : ^shift_q);
            state_d = STOP;
         end
         STOP: if (last) begin
            stp_pend_d = ~sampled_bit;
            p_data_d = sampled_bit && !par_pend_q ? shift_q : p_data_q;
            state_d = CHECK;
         end
         CHECK: begin
            state_d = IDLE;
            edge_d = 6'd0;
         end
         default: state_d = IDLE;
      endcase
   end
   // state register; reset aborts any frame in progress
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         edge_q <= '0;
         bit_q <= '0;
         p_q <= PRESCALE_8;
         par_en_q <= 1'b0;
         par_typ_q <= PAR_EVEN;
         par_pend_q <= 1'b0;
         stp_pend_q <= 1'b0;
         shift_q <= '0;
         p_data_q <= '0;
      end else begin
         state_q <= state_d;
         edge_q <= edge_d;
         bit_q <= bit_d;
         p_q <= p_d;
         par_en_q <= par_en_d;
         par_typ_q <= par_typ_d;
         par_pend_q <= par_pend_d;
         stp_pend_q <= stp_pend_d;
         shift_q <= shift_d;
         p_data_q <= p_data_d;
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with hand-computed results for uart_rx
module tb_uart_rx;
   import uart_rx_pkg::*;
   logic clk = 1'b0, rst = 1'b1, rx = 1'b1, par_en = 1'b0, par_typ = 1'b0;
   logic [5:0] prescale = PRESCALE_8;
   logic [7:0] p_data;
   logic data_valid, par_err, stp_err;
   int checks = 0, errors = 0, cyc = 0, dv_n = 0, pe_n = 0, se_n = 0, dv_cyc = 0, start_cyc = 0;
   logic [7:0] rxq[$];
   always #5 clk = ~clk;
   uart_rx dut (
      .CLK        (clk),
      .RST        (rst),
      .RX_IN      (rx),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .Prescale   (prescale),
      .P_DATA     (p_data),
      .data_valid (data_valid),
      .par_err    (par_err),
      .stp_err    (stp_err)
   );
   // cycle counter
   always @(posedge clk) cyc <= cyc + 1;
   // pulse monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (data_valid) begin
         dv_n <= dv_n + 1;
         dv_cyc <= cyc;
         rxq.push_back(p_data);
      end
      if (par_err) pe_n <= pe_n + 1;
      if (stp_err) se_n <= se_n + 1;
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic drive_bit(input logic b, input int p);
      rx = b;
      repeat (p) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input logic [7:0] d, input int p, input logic pen, input logic pb, input logic sb);
      start_cyc = cyc;
      drive_bit(1'b0, p);
      for (int i = 0; i < 8; i++) drive_bit(d[i], p);
      if (pen) drive_bit(pb, p);
      drive_bit(sb, p);
      rx = 1'b1;
   endtask
   task automatic frame_check(input string tag, input logic [7:0] d, input int p, input logic pen,
                              input logic pb, input logic sb, input int edv, input int epe,
                              input int ese, input logic [7:0] epd);
      int dv0, pe0, se0;
      dv0 = dv_n;
      pe0 = pe_n;
      se0 = se_n;
      send(d, p, pen, pb, sb);
      repeat (3) @(posedge clk);
      #1;
      check({tag, " data_valid pulses"}, dv_n - dv0, edv);
      check({tag, " par_err pulses"}, pe_n - pe0, epe);
      check({tag, " stp_err pulses"}, se_n - se0, ese);
      check({tag, " P_DATA"}, p_data, epd);
   endtask
   task automatic quiet_check(input string tag, input int dv0, input int pe0, input int se0);
      check({tag, " no pulses"}, (dv_n - dv0) + (pe_n - pe0) + (se_n - se0), 0);
   endtask
   initial begin
      int dv0, pe0, se0;
      #1;
      check("reset P_DATA", p_data, 8'h00);
      check("reset data_valid", data_valid, 0);
      check("reset par_err", par_err, 0);
      check("reset stp_err", stp_err, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // 8N1 at P=8
      frame_check("t1", 8'hA5, 8, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'hA5);
      check("t1 latency", dv_cyc - start_cyc, 80);
      // P=16 even parity: good then bad parity bit
      prescale = PRESCALE_16;
      par_en = 1'b1;
      par_typ = PAR_EVEN;
      frame_check("t2 good", 8'h3C, 16, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'h3C);
      frame_check("t2 bad", 8'h3C, 16, 1'b1, 1'b1, 1'b1, 0, 1, 0, 8'h3C);
      // P=32 odd parity, correct parity bit, stop bit 0
      prescale = PRESCALE_32;
      par_typ = PAR_ODD;
      frame_check("t3", 8'h01, 32, 1'b1, 1'b0, 1'b0, 0, 0, 1, 8'h3C);
      // glitch shorter than half a bit, then a real frame
      prescale = PRESCALE_8;
      par_en = 1'b0;
      dv0 = dv_n;
      pe0 = pe_n;
      se0 = se_n;
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 12);
      quiet_check("t4 glitch", dv0, pe0, se0);
      frame_check("t4", 8'h5A, 8, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h5A);
      // back-to-back even-parity frames with one idle cycle between them
      par_en = 1'b1;
      par_typ = PAR_EVEN;
      rxq.delete();
      dv0 = dv_n;
      send(8'h00, 8, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1);
      send(8'hFF, 8, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 1);
      send(8'h81, 8, 1'b1, 1'b0, 1'b1);
      drive_bit(1'b1, 4);
      check("t5 data_valid pulses", dv_n - dv0, 3);
      check("t5 frame0", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h00);
      check("t5 frame1", rxq.size() > 1 ? rxq[1] : 8'hxx, 8'hFF);
      check("t5 frame2", rxq.size() > 2 ? rxq[2] : 8'hxx, 8'h81);
      // reset during data bit 4 of 0xC3
      par_en = 1'b0;
      dv0 = dv_n;
      pe0 = pe_n;
      se0 = se_n;
      drive_bit(1'b0, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b1, 8);
      drive_bit(1'b0, 8);
      drive_bit(1'b0, 8);
      drive_bit(1'b0, 4);
      #2;
      rst = 1'b1;
      #1;
      check("t6 reset P_DATA", p_data, 8'h00);
      check("t6 reset data_valid", data_valid, 0);
      rx = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive_bit(1'b1, 12);
      quiet_check("t6 abort", dv0, pe0, se0);
      frame_check("t6", 8'h96, 8, 1'b0, 1'b0, 1'b1, 1, 0, 0, 8'h96);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
